// File: rtl/blackjack_game_ctrl.sv
// Single-player blackjack round controller: deals over a req/valid card handshake, scores hands
// with soft-ace handling, runs player and dealer turns, and keeps saturating win/lose/tie counters.
module blackjack_game_ctrl #(
    parameter int unsigned BUST_LIMIT   = 21,
    parameter int unsigned DEALER_STAND = 17,
    parameter int unsigned SOFT_HIT     = 0,
    parameter int unsigned HAND_W       = 6,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              hit,
    input  logic              stay,
    output logic              card_req,
    input  logic              card_valid,
    input  logic [3:0]        card_in,
    output logic              card_err,
    output logic [HAND_W-1:0] player_hand,
    output logic [HAND_W-1:0] dealer_hand,
    output logic [3:0]        state_o,
    output logic              result_valid,
    output logic [1:0]        outcome,
    output logic [CNT_W-1:0]  win,
    output logic [CNT_W-1:0]  lose,
    output logic [CNT_W-1:0]  tie
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        PL_TURN = 4'd5,
        PL_DRAW = 4'd6,
        DL_TURN = 4'd7,
        RESOLVE = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        OUT_NONE = 2'b00,
        OUT_WIN  = 2'b01,
        OUT_LOSE = 2'b10,
        OUT_TIE  = 2'b11
    } outcome_e;

    localparam logic [HAND_W-1:0] BL_H  = BUST_LIMIT[HAND_W-1:0];
    localparam logic [HAND_W-1:0] DS_H  = DEALER_STAND[HAND_W-1:0];
    localparam logic [HAND_W-1:0] TEN_H = HAND_W'(10);

    state_e              state_q, state_d;
    logic [HAND_W-1:0]   p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic                p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [1:0]          p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    outcome_e            outcome_q, outcome_d;
    logic [CNT_W-1:0]    win_q, win_d, lose_q, lose_d, tie_q, tie_d;

    logic                rank_legal, take, to_player, dl_draw;
    logic [HAND_W-1:0]   card_pts, p_eff, d_eff;
    logic                p_bust, d_bust, p_nat, d_nat, p_nat_d, d_nat_d;
    logic [HAND_W-1:0]   p_eff_d;
    outcome_e            res;

    // An ace counts 11 only while that keeps the hand at or below the bust limit.
    function automatic logic boost_ok(input logic [HAND_W-1:0] hard, input logic ace);
        return ace && (({1'b0, hard} + {1'b0, TEN_H}) <= {1'b0, BL_H});
    endfunction

    function automatic logic [HAND_W-1:0] effective(input logic [HAND_W-1:0] hard, input logic ace);
        return boost_ok(hard, ace) ? hard + TEN_H : hard;
    endfunction

    assign rank_legal = (card_in != 4'd0) && (card_in <= 4'd13);
    assign card_pts   = (card_in > 4'd10) ? TEN_H : {{(HAND_W-4){1'b0}}, card_in};
    assign p_eff      = effective(p_hard_q, p_ace_q);
    assign d_eff      = effective(d_hard_q, d_ace_q);
    assign p_bust     = p_eff > BL_H;
    assign d_bust     = d_eff > BL_H;
    assign p_nat      = (p_cnt_q == 2'd2) && (p_eff == BL_H);
    assign d_nat      = (d_cnt_q == 2'd2) && (d_eff == BL_H);
    assign dl_draw    = (d_eff < DS_H) ||
                        ((SOFT_HIT != 0) && boost_ok(d_hard_q, d_ace_q) && (d_eff == DS_H));
    assign to_player  = (state_q == DEAL_P1) || (state_q == DEAL_P2) || (state_q == PL_DRAW);

    always_comb begin
        card_req = 1'b0;
        case (state_q)
            DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PL_DRAW: card_req = 1'b1;
            DL_TURN:                                     card_req = dl_draw;
            default:                                     card_req = 1'b0;
        endcase
    end

    assign take     = card_req && card_valid && rank_legal;
    assign card_err = card_req && card_valid && !rank_legal;

    always_comb begin
        if (p_bust)              res = OUT_LOSE;
        else if (p_nat && d_nat) res = OUT_TIE;
        else if (p_nat)          res = OUT_WIN;
        else if (d_nat)          res = OUT_LOSE;
        else if (d_bust)         res = OUT_WIN;
        else if (p_eff > d_eff)  res = OUT_WIN;
        else if (p_eff < d_eff)  res = OUT_LOSE;
        else                     res = OUT_TIE;
    end

    always_comb begin
        state_d   = state_q;
        p_hard_d  = p_hard_q;
        p_ace_d   = p_ace_q;
        p_cnt_d   = p_cnt_q;
        d_hard_d  = d_hard_q;
        d_ace_d   = d_ace_q;
        d_cnt_d   = d_cnt_q;
        outcome_d = outcome_q;
        win_d     = win_q;
        lose_d    = lose_q;
        tie_d     = tie_q;

        if (take) begin
            if (to_player) begin
                p_hard_d = p_hard_q + card_pts;
                p_ace_d  = p_ace_q || (card_in == 4'd1);
                if (p_cnt_q != 2'd3) p_cnt_d = p_cnt_q + 2'd1;
            end else begin
                d_hard_d = d_hard_q + card_pts;
                d_ace_d  = d_ace_q || (card_in == 4'd1);
                if (d_cnt_q != 2'd3) d_cnt_d = d_cnt_q + 2'd1;
            end
        end

        // Post-card decisions look at the hand including the card accepted this cycle.
        p_eff_d = effective(p_hard_d, p_ace_d);
        p_nat_d = (p_cnt_d == 2'd2) && (p_eff_d == BL_H);
        d_nat_d = (d_cnt_d == 2'd2) && (effective(d_hard_d, d_ace_d) == BL_H);

        case (state_q)
            IDLE: begin
                if (new_game) begin
                    state_d   = DEAL_P1;
                    p_hard_d  = '0;
                    p_ace_d   = 1'b0;
                    p_cnt_d   = '0;
                    d_hard_d  = '0;
                    d_ace_d   = 1'b0;
                    d_cnt_d   = '0;
                    outcome_d = OUT_NONE;
                end
            end
            DEAL_P1: if (take) state_d = DEAL_D1;
            DEAL_D1: if (take) state_d = DEAL_P2;
            DEAL_P2: if (take) state_d = DEAL_D2;
            DEAL_D2: if (take) state_d = (p_nat_d || d_nat_d) ? RESOLVE : PL_TURN;
            PL_TURN: begin
                if (stay)     state_d = DL_TURN;
                else if (hit) state_d = PL_DRAW;
            end
            PL_DRAW: begin
                if (take) begin
                    if (p_eff_d > BL_H)       state_d = RESOLVE;
                    else if (p_eff_d == BL_H) state_d = DL_TURN;
                    else                      state_d = PL_TURN;
                end
            end
            DL_TURN: if (!dl_draw) state_d = RESOLVE;
            RESOLVE: begin
                state_d   = IDLE;
                outcome_d = res;
                case (res)
                    OUT_WIN:  if (win_q  != '1) win_d  = win_q  + 1'b1;
                    OUT_LOSE: if (lose_q != '1) lose_d = lose_q + 1'b1;
                    OUT_TIE:  if (tie_q  != '1) tie_d  = tie_q  + 1'b1;
                    default:  ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            p_hard_q  <= '0;
            p_ace_q   <= 1'b0;
            p_cnt_q   <= '0;
            d_hard_q  <= '0;
            d_ace_q   <= 1'b0;
            d_cnt_q   <= '0;
            outcome_q <= OUT_NONE;
            win_q     <= '0;
            lose_q    <= '0;
            tie_q     <= '0;
        end else begin
            state_q   <= state_d;
            p_hard_q  <= p_hard_d;
            p_ace_q   <= p_ace_d;
            p_cnt_q   <= p_cnt_d;
            d_hard_q  <= d_hard_d;
            d_ace_q   <= d_ace_d;
            d_cnt_q   <= d_cnt_d;
            outcome_q <= outcome_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            tie_q     <= tie_d;
        end
    end

    assign player_hand  = p_eff;
    assign dealer_hand  = d_eff;
    assign state_o      = state_q;
    assign result_valid = (state_q == RESOLVE);
    assign outcome      = (state_q == RESOLVE) ? res : outcome_q;
    assign win          = win_q;
    assign lose         = lose_q;
    assign tie          = tie_q;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Bench for blackjack_game_ctrl: directed rounds plus randomized rounds scored by a card-list model.
module tb_blackjack_game_ctrl;

    localparam int BL = 21;
    localparam int DS = 17;

    logic       clk = 1'b0;
    logic       reset, new_game, hit, stay, card_valid;
    logic [3:0] card_in;

    logic       card_req, card_err, result_valid;
    logic [5:0] player_hand, dealer_hand;
    logic [3:0] state_o;
    logic [1:0] outcome;
    logic [7:0] win, lose, tie;

    logic       s_card_req, s_card_err, s_result_valid;
    logic [5:0] s_player_hand, s_dealer_hand;
    logic [3:0] s_state_o;
    logic [1:0] s_outcome;
    logic [7:0] s_win, s_lose, s_tie;

    blackjack_game_ctrl #(.SOFT_HIT(0)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .hit(hit), .stay(stay),
        .card_req(card_req), .card_valid(card_valid), .card_in(card_in), .card_err(card_err),
        .player_hand(player_hand), .dealer_hand(dealer_hand), .state_o(state_o),
        .result_valid(result_valid), .outcome(outcome), .win(win), .lose(lose), .tie(tie)
    );

    blackjack_game_ctrl #(.SOFT_HIT(1)) dut_s (
        .clk(clk), .reset(reset), .new_game(new_game), .hit(hit), .stay(stay),
        .card_req(s_card_req), .card_valid(card_valid), .card_in(card_in), .card_err(s_card_err),
        .player_hand(s_player_hand), .dealer_hand(s_dealer_hand), .state_o(s_state_o),
        .result_valid(s_result_valid), .outcome(s_outcome), .win(s_win), .lose(s_lose), .tie(s_tie)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int deck_q[$];
    bit auto_deck = 1'b0;
    bit pend = 1'b0;
    int valid_pct = 100;
    int bad_pct = 0;
    int cards_used = 0;

    // Automatic card source: presents the deck head (or occasionally an illegal rank) with gaps.
    always @(negedge clk) begin
        if (auto_deck) begin
            if (pend) begin
                void'(deck_q.pop_front());
                cards_used++;
            end
            pend = 1'b0;
            card_valid = 1'b0;
            card_in = 4'd0;
            if (deck_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                card_valid = 1'b1;
                if ($urandom_range(99) < bad_pct)
                    card_in = ($urandom_range(1) == 0) ? 4'd0 : 4'(13 + $urandom_range(2, 1));
                else
                    card_in = 4'(deck_q[0]);
            end
            #1 pend = card_valid && card_req && card_in >= 1 && card_in <= 13;
        end
    end

    int pq[$];
    int dq[$];
    int md[$];

    function automatic int total(input bit dealer);
        int s = 0;
        bit a = 0;
        int n = dealer ? dq.size() : pq.size();
        for (int i = 0; i < n; i++) begin
            int r = dealer ? dq[i] : pq[i];
            s += (r > 10) ? 10 : r;
            if (r == 1) a = 1;
        end
        return (a && s + 10 <= BL) ? s + 10 : s;
    endfunction

    task automatic model_round(input int thresh, output int e_out, output int e_p, output int e_d,
                               output int e_used, output int e_hits);
        bit pn, dn;
        int p, d;
        md = deck_q;
        pq = {};
        dq = {};
        pq.push_back(md.pop_front());
        dq.push_back(md.pop_front());
        pq.push_back(md.pop_front());
        dq.push_back(md.pop_front());
        pn = (total(0) == BL);
        dn = (total(1) == BL);
        e_hits = 0;
        if (!pn && !dn) begin
            while (total(0) < thresh && total(0) < BL) begin
                pq.push_back(md.pop_front());
                e_hits++;
            end
            if (total(0) <= BL)
                while (total(1) < DS) dq.push_back(md.pop_front());
        end
        p = total(0);
        d = total(1);
        if (p > BL)          e_out = 2;
        else if (pn && dn)   e_out = 3;
        else if (pn)         e_out = 1;
        else if (dn)         e_out = 2;
        else if (d > BL)     e_out = 1;
        else if (p > d)      e_out = 1;
        else if (p < d)      e_out = 2;
        else                 e_out = 3;
        e_p = p;
        e_d = d;
        e_used = pq.size() + dq.size();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_ng();
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
    endtask

    task automatic hit_p();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
    endtask

    task automatic stay_p();
        stay = 1'b1;
        cyc();
        stay = 1'b0;
    endtask

    task automatic give(input int r);
        int n = 0;
        while (!card_req && n < 20) begin
            cyc();
            n++;
        end
        if (!card_req) check("give_req_timeout", card_req, 1);
        card_valid = 1'b1;
        card_in = 4'(r);
        cyc();
        card_valid = 1'b0;
        card_in = 4'd0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!result_valid && n < 50) begin
            cyc();
            n++;
        end
        if (!result_valid) check("result_timeout", result_valid, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_out, e_p, e_d, e_used, e_hits, thresh, hits, guard;
        int mw, ml, mt;

        reset = 1'b1; new_game = 1'b0; hit = 1'b0; stay = 1'b0;
        card_valid = 1'b0; card_in = 4'd0;
        @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_req", card_req, 0);
        check("rst_rv", result_valid, 0);
        check("rst_outcome", outcome, 0);
        check("rst_phand", player_hand, 0);
        check("rst_dhand", dealer_hand, 0);
        check("rst_cnt", {win, lose, tie}, 0);
        reset = 1'b0;
        cyc();

        // Player 20 stands, dealer 16 draws a 5 to 21.
        pulse_ng();
        check("t1_state_p1", state_o, 1);
        check("t1_req", card_req, 1);
        give(10); give(7); give(10); give(9);
        check("t1_pl_turn", state_o, 5);
        check("t1_phand", player_hand, 20);
        check("t1_dhand", dealer_hand, 16);
        stay_p();
        check("t1_dl_turn", state_o, 7);
        check("t1_dl_req", card_req, 1);
        give(5);
        check("t1_dhand21", dealer_hand, 21);
        wait_result();
        check("t1_outcome", outcome, 2);
        cyc();
        check("t1_lose", lose, 1);
        check("t1_idle", state_o, 0);
        check("t1_outcome_held", outcome, 2);

        // Player natural resolves straight after the deal.
        pulse_ng();
        check("t2_outcome_clr", outcome, 0);
        check("t2_phand_clr", player_hand, 0);
        give(1); give(10); give(13); give(6);
        check("t2_resolve", state_o, 8);
        check("t2_rv", result_valid, 1);
        check("t2_outcome", outcome, 1);
        check("t2_phand", player_hand, 21);
        cyc();
        check("t2_win", win, 1);

        // Soft 17 vs soft 17; hit and stay together means stay.
        pulse_ng();
        give(1); give(1); give(6); give(6);
        check("t3_phand", player_hand, 17);
        check("t3_dhand", dealer_hand, 17);
        hit = 1'b1;
        stay_p();
        hit = 1'b0;
        check("t3_dl_turn", state_o, 7);
        check("t3_no_draw", card_req, 0);
        check("t3_softhit_req", s_card_req, 1);
        wait_result();
        check("t3_outcome", outcome, 3);
        cyc();
        check("t3_tie", tie, 1);

        // Player busts on a hit; dealer never asks for a card.
        pulse_ng();
        give(10); give(5); give(6); give(7);
        check("t4_pl_turn", state_o, 5);
        hit_p();
        check("t4_pl_draw", state_o, 6);
        give(9);
        check("t4_resolve", state_o, 8);
        check("t4_no_dreq", card_req, 0);
        check("t4_phand", player_hand, 25);
        check("t4_dhand", dealer_hand, 12);
        check("t4_outcome", outcome, 2);
        cyc();
        check("t4_lose", lose, 2);

        // card_valid without card_req, then an illegal rank during DEAL_P1.
        card_valid = 1'b1;
        card_in = 4'd5;
        for (int i = 0; i < 3; i++) cyc();
        check("t5_idle", state_o, 0);
        check("t5_idle_req", card_req, 0);
        check("t5_idle_err", card_err, 0);
        check("t5_phand_held", player_hand, 25);
        new_game = 1'b1;
        card_in = 4'd14;
        cyc();
        new_game = 1'b0;
        #1;
        check("t5_err", card_err, 1);
        check("t5_req", card_req, 1);
        cyc();
        check("t5_still_p1", state_o, 1);
        check("t5_req_held", card_req, 1);
        check("t5_phand0", player_hand, 0);
        card_in = 4'd5;
        #1;
        check("t5_err_clear", card_err, 0);
        cyc();
        card_valid = 1'b0;
        check("t5_accept", state_o, 2);
        check("t5_phand5", player_hand, 5);

        // Continue into a drawing dealer turn, then reset asynchronously.
        give(10); give(2); give(6);
        stay_p();
        check("t6_dl_turn", state_o, 7);
        reset = 1'b1;
        #1;
        check("t6_rst_state", state_o, 0);
        check("t6_rst_cnt", {win, lose, tie}, 0);
        check("t6_rst_req", card_req, 0);
        cyc();
        reset = 1'b0;
        cyc();
        hit_p();
        check("t6_idle_hit", state_o, 0);
        stay_p();
        check("t6_idle_stay", state_o, 0);
        check("t6_idle_hands", {player_hand, dealer_hand}, 0);

        // Randomized rounds against the card-list model.
        mw = 0; ml = 0; mt = 0;
        auto_deck = 1'b1;
        for (int r = 0; r < 40; r++) begin
            deck_q = {};
            for (int i = 0; i < 24; i++) deck_q.push_back(int'($urandom_range(13, 1)));
            cards_used = 0;
            valid_pct = int'($urandom_range(100, 40));
            bad_pct = int'($urandom_range(20, 0));
            thresh = int'($urandom_range(21, 12));
            model_round(thresh, e_out, e_p, e_d, e_used, e_hits);
            pulse_ng();
            hits = 0;
            guard = 0;
            while (!result_valid && guard < 400) begin
                if (state_o == 4'd5) begin
                    if (hits < e_hits) begin
                        hit_p();
                        hits++;
                    end else begin
                        stay_p();
                    end
                end else begin
                    cyc();
                end
                guard++;
            end
            if (!result_valid) check("rnd_timeout", result_valid, 1);
            check("rnd_outcome", outcome, e_out);
            check("rnd_phand", player_hand, e_p);
            check("rnd_dhand", dealer_hand, e_d);
            if (e_out == 1) mw++;
            else if (e_out == 2) ml++;
            else mt++;
            cyc();
            check("rnd_cards_used", cards_used, e_used);
            check("rnd_win", win, mw);
            check("rnd_lose", lose, ml);
            check("rnd_tie", tie, mt);
        end
        auto_deck = 1'b0;
        #2;
        card_valid = 1'b0;
        card_in = 4'd0;
        cyc();

        // Win counter saturation.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 256; i++) begin
            pulse_ng();
            give(1); give(10); give(13); give(6);
            cyc();
            if (i == 254) check("sat_win_255", win, 255);
        end
        check("sat_win_held", win, 255);
        check("sat_lose", lose, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
